// File: rtl/p2p_frame_tx.sv
// p2p_frame_tx -- transmit-side framer for the point-to-point link.
//
// Collects one payload packet of 1..MAX_LEN bytes from the local node into
// an internal buffer. It then sends the packet to the peer as one frame:
//   header   = {NODE_ID, payload length}
//   payload  = the buffered bytes, in order
//   checksum = two's complement of (header + payload), so the whole frame
//              sums to 0 mod 256
// Only one packet is in flight at a time. in_ready stays low from the last
// payload byte until the checksum has been accepted.
//
// Ports:
//   clk, rst    single clock; asynchronous active-high reset
//   in_data     payload byte from the local node
//   in_valid    in_data is valid
//   in_last     in_data is the final byte of the packet
//   in_ready    framer can accept a payload byte (high only in FILL)
//   link_data   frame byte to the peer
//   link_valid  link_data is valid; held until link_ready
//   link_ready  peer accepts link_data this cycle
//   pkt_done    one-cycle pulse after the checksum byte is accepted
//   busy        a packet is being collected or framed

module p2p_frame_tx #(
    parameter logic [3:0] NODE_ID = 4'h1,
    parameter int         MAX_LEN = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] link_data,
    output logic       link_valid,
    input  logic       link_ready,
    output logic       pkt_done,
    output logic       busy
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        CSUM = 2'd3
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_LEN);

    state_t     state;
    logic [3:0] count;
    logic [3:0] count_inc;
    logic [3:0] rd_ptr;
    logic [7:0] sum;
    logic [7:0] pbuf [16];

    logic in_xfer;
    logic link_xfer;

    assign in_xfer   = in_valid && in_ready;
    assign link_xfer = link_valid && link_ready;
    assign count_inc = count + 4'd1;

    // NOTE: the payload buffer has no reset. Every entry is written before it
    // is read in each frame, so clearing it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (state == FILL && in_xfer) begin
            pbuf[count] <= in_data;
        end
    end

    // All outputs are registered and change only on a transfer. That keeps
    // link_data and link_valid stable while the peer stalls.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            count      <= 4'd0;
            sum        <= 8'h00;
            rd_ptr     <= 4'd0;
            in_ready   <= 1'b1;
            link_valid <= 1'b0;
            link_data  <= 8'h00;
            pkt_done   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            case (state)
                FILL: begin
                    if (in_xfer) begin
                        count <= count_inc;
                        sum   <= sum + in_data;
                        busy  <= 1'b1;
                        // A full buffer ends the packet even without in_last.
                        if (in_last || count_inc == MAX_CNT) begin
                            state      <= HDR;
                            in_ready   <= 1'b0;
                            link_valid <= 1'b1;
                            link_data  <= {NODE_ID, count_inc};
                        end
                    end
                end

                HDR: begin
                    if (link_xfer) begin
                        // The header is part of the checksummed data.
                        sum       <= sum + link_data;
                        rd_ptr    <= 4'd0;
                        link_data <= pbuf[0];
                        state     <= DATA;
                    end
                end

                DATA: begin
                    if (link_xfer) begin
                        if (rd_ptr == count - 4'd1) begin
                            // sum already holds header + all payload bytes.
                            link_data <= (~sum) + 8'd1;
                            state     <= CSUM;
                        end else begin
                            rd_ptr    <= rd_ptr + 4'd1;
                            link_data <= pbuf[rd_ptr + 4'd1];
                        end
                    end
                end

                CSUM: begin
                    if (link_xfer) begin
                        pkt_done   <= 1'b1;
                        count      <= 4'd0;
                        sum        <= 8'h00;
                        link_valid <= 1'b0;
                        link_data  <= 8'h00;
                        in_ready   <= 1'b1;
                        busy       <= 1'b0;
                        state      <= FILL;
                    end
                end

                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_p2p_frame_tx.sv
// Self-checking bench for p2p_frame_tx.
//
// The reference model works on whole packets and frames. Payload bytes build
// up in a queue. When a packet ends, the model builds its full frame
// (header, payload, negated sum) in an expected-byte queue. The link must
// show the head of that queue until it is accepted. in_ready is expected
// only while no frame is pending. A compare process checks every output on
// every falling edge. Directed cases also pin the logged link bytes to
// hand-computed literal frames.

module tb_p2p_frame_tx;

    localparam logic [3:0] NODE_ID = 4'h1;
    localparam int         MAX_LEN = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] link_data;
    logic       link_valid;
    logic       link_ready;
    logic       pkt_done;
    logic       busy;

    p2p_frame_tx #(.NODE_ID(NODE_ID), .MAX_LEN(MAX_LEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .link_data  (link_data),
        .link_valid (link_valid),
        .link_ready (link_ready),
        .pkt_done   (pkt_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [7:0] pend[$];
    logic [7:0] frame[$];
    bit         exp_done = 1'b0;

    // Observation state
    int         cyc = 0;
    logic [7:0] log_q[$];
    logic [7:0] expq[$];
    int         done_cnt = 0;
    int         last_done_cyc = -1;
    int         ir_low = 0;
    int         lr_mode = 2;   // 0: link_ready=1, 1: random, 2: driven by main

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void build_frame();
        logic [7:0] s;
        logic [7:0] hdr;
        hdr = {NODE_ID, 4'(pend.size())};
        s   = hdr;
        frame.push_back(hdr);
        foreach (pend[i]) begin
            frame.push_back(pend[i]);
            s = s + pend[i];
        end
        frame.push_back(8'h00 - s);
        pend.delete();
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (lr_mode == 0) link_ready = 1'b1;
        else if (lr_mode == 1) link_ready = 1'($urandom_range(0, 1));
    end

    // Compare process: check against the model, then advance the model with
    // the transfers that will happen on the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", {31'd0, in_ready}, {31'd0, frame.size() == 0});
            check("link_valid", {31'd0, link_valid}, {31'd0, frame.size() != 0});
            if (frame.size() != 0) check("link_data", {24'd0, link_data}, {24'd0, frame[0]});
            check("busy", {31'd0, busy}, {31'd0, (pend.size() != 0) || (frame.size() != 0)});
            check("pkt_done", {31'd0, pkt_done}, {31'd0, exp_done});
            if (pkt_done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (!in_ready) ir_low++;
            if (link_valid && link_ready) log_q.push_back(link_data);

            exp_done = 1'b0;
            if (frame.size() != 0) begin
                if (link_ready) begin
                    void'(frame.pop_front());
                    if (frame.size() == 0) exp_done = 1'b1;
                end
            end else if (in_valid) begin
                pend.push_back(in_data);
                if (in_last || pend.size() == MAX_LEN) build_frame();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, output int acc);
        int   n;
        logic ok;
        n        = 0;
        ok       = 1'b0;
        acc      = -1;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        while (!ok && n < 500) begin
            @(negedge clk);
            ok  = in_ready;
            acc = cyc;
            tick();
            n++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_byte_timeout: byte %0h never accepted", d);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pkt_done && n < 300);
        if (!pkt_done) begin
            tests++;
            fails++;
            $display("FAIL wait_done_timeout: pkt_done not seen in %0d cycles", n);
        end
        tick();
    endtask

    task automatic check_log(input string name);
        check({name, "_len"}, 32'(log_q.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size(); i++) begin
            if (i < log_q.size()) check(name, {24'd0, log_q[i]}, {24'd0, expq[i]});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int acc16;
        int d1;
        int len;
        int n;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        in_data    = 8'h00;
        link_ready = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_link_valid", {31'd0, link_valid}, 32'd0);
        check("rst_link_data", {24'd0, link_data}, 32'd0);
        check("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        #12;
        rst = 1'b0;
        tick();

        // Basic 3-byte frame with the link always ready.
        lr_mode    = 0;
        link_ready = 1'b1;
        log_q.delete();
        done_cnt = 0;
        send_byte(8'h10, 1'b0, acc);
        send_byte(8'h20, 1'b0, acc);
        send_byte(8'h30, 1'b1, acc);
        wait_done();
        expq = {8'h13, 8'h10, 8'h20, 8'h30, 8'h8D};
        check_log("frame3");
        check("frame3_done_cnt", 32'(done_cnt), 32'd1);

        // Single byte: in_ready low for exactly the 3 link cycles.
        log_q.delete();
        ir_low = 0;
        send_byte(8'hFF, 1'b1, acc);
        wait_done();
        expq = {8'hFF};
        expq = {8'h11, 8'hFF, 8'hF0};
        check_log("frame1");
        check("frame1_in_ready_low", 32'(ir_low), 32'd3);

        // 16 bytes without in_last: forced end after 15, byte 16 waits.
        log_q.delete();
        done_cnt = 0;
        acc16    = -1;
        for (int i = 1; i <= 16; i++) begin
            send_byte(8'(i), 1'b0, acc);
            if (i == 16) acc16 = acc;
        end
        d1 = last_done_cyc;
        check("forced_16th_after_done", 32'(acc16), 32'(d1));
        send_byte(8'h11, 1'b1, acc);
        wait_done();
        expq = {8'h1F, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h69,
                8'h12, 8'h10, 8'h11, 8'hCD};
        check_log("forced");
        check("forced_done_cnt", 32'(done_cnt), 32'd2);

        // Backpressure: 4 stall cycles on the header, 2 on payload 0x20.
        lr_mode    = 2;
        link_ready = 1'b0;
        log_q.delete();
        send_byte(8'h10, 1'b0, acc);
        send_byte(8'h20, 1'b0, acc);
        send_byte(8'h30, 1'b1, acc);
        repeat (4) tick();
        link_ready = 1'b1;
        tick();
        tick();
        link_ready = 1'b0;
        repeat (2) tick();
        link_ready = 1'b1;
        wait_done();
        expq = {8'h13, 8'h10, 8'h20, 8'h30, 8'h8D};
        check_log("stall");

        // Reset in DATA after 0x10 has been sent.
        send_byte(8'h10, 1'b0, acc);
        send_byte(8'h20, 1'b0, acc);
        send_byte(8'h30, 1'b1, acc);
        tick();
        tick();
        #2;
        rst = 1'b1;
        pend.delete();
        frame.delete();
        exp_done = 1'b0;
        #1;
        check("midrst_link_valid", {31'd0, link_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        tick();
        log_q.delete();
        send_byte(8'hAA, 1'b1, acc);
        wait_done();
        expq = {8'h11, 8'hAA, 8'h45};
        check_log("after_rst");

        // Back-to-back packets. The second frame sums to 0x1F, so its
        // checksum is 0xE1.
        lr_mode = 0;
        log_q.delete();
        send_byte(8'h05, 1'b1, acc);
        send_byte(8'h06, 1'b0, acc);
        check("b2b_first_byte_cycle", 32'(acc), 32'(last_done_cyc));
        send_byte(8'h07, 1'b1, acc);
        wait_done();
        expq = {8'h11, 8'h05, 8'hEA, 8'h12, 8'h06, 8'h07, 8'hE1};
        check_log("b2b");

        // Random packets, gaps and link backpressure, checked by the model.
        lr_mode = 1;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 18);
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                send_byte(8'($urandom), (i == len - 1), acc);
            end
        end
        lr_mode = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 500);
        check("random_drain_idle", {31'd0, busy}, 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
